// File: rtl/bcrypt_pkg.sv
// -----------------------------------------------------------------------------
// bcrypt_pkg
// Shared definitions for the bcrypt core-side batch receiver: bus control
// codes, batch word counts / base addresses and the receiver state enum.
// -----------------------------------------------------------------------------
package bcrypt_pkg;

  // Batch geometry
  localparam int INIT_P_WORDS = 30;
  localparam int S_WORDS      = 1024;
  localparam int DATA_WORDS   = 31;
  localparam int DATA_BASE    = 32;
  localparam int INIT_WORDS   = INIT_P_WORDS + S_WORDS;

  // ctrl[1:0] encodings on the batch bus
  localparam logic [1:0] CTRL_NONE       = 2'd0;
  localparam logic [1:0] CTRL_INIT_START = 2'd1;
  localparam logic [1:0] CTRL_DATA_START = 2'd2;
  localparam logic [1:0] CTRL_END        = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_INIT = 2'd1,
    ST_RX_DATA = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  // Maximum number of words a batch of the given kind may carry
  function automatic logic [10:0] batch_limit(input state_e st);
    return (st == ST_RX_INIT) ? 11'(INIT_WORDS) : 11'(DATA_WORDS);
  endfunction

endpackage

// File: rtl/bcrypt_byte_to_word.sv
// -----------------------------------------------------------------------------
// bcrypt_byte_to_word
// Collects a little-endian byte stream into 32-bit words. Byte 0 lands in
// bits [7:0]; the word is presented combinationally together with its 4th byte.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   byte_in     - incoming byte
//   byte_valid  - byte_in carries a byte this cycle
//   clear       - restart at byte 0 with an empty assembly register
//   word        - {byte_in, bytes 2..0 collected so far}
//   word_valid  - byte_in is byte 3, word is complete this cycle
// -----------------------------------------------------------------------------
module bcrypt_byte_to_word (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (clear) begin
      byte_cnt_d = 2'd0;
      asm_d      = '0;
    end else if (byte_valid) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      // Byte 3 is never stored: it goes straight out with the word
      case (byte_cnt_q)
        2'd0:    asm_d[7:0]   = byte_in;
        2'd1:    asm_d[15:8]  = byte_in;
        2'd2:    asm_d[23:16] = byte_in;
        default: asm_d        = asm_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

  assign word       = {byte_in, asm_q};
  assign word_valid = byte_valid && !clear && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/bcrypt_core_din.sv
// -----------------------------------------------------------------------------
// bcrypt_core_din
// Core-side receiver for the 10-bit batch bus from the bcrypt data
// distributor. Rebuilds 32-bit words and writes init batches into P[0..29]
// and S[0..1023], data batches into P[32..62]. Flags framing errors (sticky).
// Ports:
//   CLK, rst_n            - clock, asynchronous active-low reset
//   din, ctrl             - bus byte and control code
//   core_idle             - core is not using P/S memories
//   wr_data               - registered word for either memory
//   p_wr_en, p_wr_addr    - P/MW memory write strobe and address
//   s_wr_en, s_wr_addr    - S memory write strobe and address
//   init_done, data_done  - one-cycle completion pulses
//   busy                  - batch in progress (also held in ERROR)
//   error                 - sticky: [0] framing error, [1] start while busy
// Build option: BCRYPT_DIN_CNT_CHECK_EN - END must arrive on exactly the
//   nominal word count of the batch, otherwise it is a framing error.
// -----------------------------------------------------------------------------
module bcrypt_core_din
  import bcrypt_pkg::*;
(
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic [1:0]  ctrl,
  input  logic        core_idle,
  output logic [31:0] wr_data,
  output logic        p_wr_en,
  output logic [5:0]  p_wr_addr,
  output logic        s_wr_en,
  output logic [9:0]  s_wr_addr,
  output logic        init_done,
  output logic        data_done,
  output logic        busy,
  output logic [1:0]  error
);

  state_e      state_q, state_d;
  logic [10:0] word_cnt_q, word_cnt_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        p_wr_en_q, p_wr_en_d;
  logic [5:0]  p_wr_addr_q, p_wr_addr_d;
  logic        s_wr_en_q, s_wr_en_d;
  logic [9:0]  s_wr_addr_q, s_wr_addr_d;
  logic        init_done_q, init_done_d;
  logic        data_done_q, data_done_d;
  logic        busy_q, busy_d;
  logic [1:0]  error_q, error_d;

  logic        in_rx, is_start, is_end, byte_valid, clear, word_valid;
  logic [31:0] word;
  logic [10:0] word_limit;

  assign in_rx      = (state_q == ST_RX_INIT) || (state_q == ST_RX_DATA);
  assign is_start   = (ctrl == CTRL_INIT_START) || (ctrl == CTRL_DATA_START);
  assign is_end     = (ctrl == CTRL_END);
  assign byte_valid = in_rx && !is_start;
  assign clear      = (state_q == ST_IDLE) && is_start;
  assign word_limit = batch_limit(state_q);

  bcrypt_byte_to_word u_b2w (
    .clk        (CLK),
    .rst_n      (rst_n),
    .byte_in    (din),
    .byte_valid (byte_valid),
    .clear      (clear),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    wr_data_d   = wr_data_q;
    p_wr_en_d   = 1'b0;
    p_wr_addr_d = '0;
    s_wr_en_d   = 1'b0;
    s_wr_addr_d = '0;
    init_done_d = 1'b0;
    data_done_d = 1'b0;
    busy_d      = busy_q;
    error_d     = error_q;

    case (state_q)
      ST_IDLE: begin
        if (is_start) begin
          word_cnt_d = '0;
          busy_d     = 1'b1;
          if (!core_idle) begin
            error_d[1] = 1'b1;
            state_d    = ST_ERROR;
          end else begin
            state_d = (ctrl == CTRL_INIT_START) ? ST_RX_INIT : ST_RX_DATA;
          end
        end
      end

      ST_RX_INIT, ST_RX_DATA: begin
        if (is_start || (is_end && !word_valid)) begin
          error_d[0] = 1'b1;
          state_d    = ST_ERROR;
        end else if (word_valid) begin
          // A completed word beyond the batch size is an overrun
          if (word_cnt_q == word_limit) begin
            error_d[0] = 1'b1;
            state_d    = ST_ERROR;
          end
`ifdef BCRYPT_DIN_CNT_CHECK_EN
          else if (is_end && (word_cnt_q != word_limit - 11'd1)) begin
            error_d[0] = 1'b1;
            state_d    = ST_ERROR;
          end
`endif
          else begin
            wr_data_d  = word;
            word_cnt_d = word_cnt_q + 11'd1;
            if (state_q == ST_RX_DATA) begin
              p_wr_en_d   = 1'b1;
              p_wr_addr_d = 6'(DATA_BASE) + word_cnt_q[5:0];
            end else if (word_cnt_q < 11'(INIT_P_WORDS)) begin
              p_wr_en_d   = 1'b1;
              p_wr_addr_d = word_cnt_q[5:0];
            end else begin
              s_wr_en_d   = 1'b1;
              s_wr_addr_d = 10'(word_cnt_q - 11'(INIT_P_WORDS));
            end
            if (is_end) begin
              init_done_d = (state_q == ST_RX_INIT);
              data_done_d = (state_q == ST_RX_DATA);
              busy_d      = 1'b0;
              state_d     = ST_IDLE;
            end
          end
        end
      end

      default: begin
        busy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      wr_data_q   <= '0;
      p_wr_en_q   <= 1'b0;
      p_wr_addr_q <= '0;
      s_wr_en_q   <= 1'b0;
      s_wr_addr_q <= '0;
      init_done_q <= 1'b0;
      data_done_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      wr_data_q   <= wr_data_d;
      p_wr_en_q   <= p_wr_en_d;
      p_wr_addr_q <= p_wr_addr_d;
      s_wr_en_q   <= s_wr_en_d;
      s_wr_addr_q <= s_wr_addr_d;
      init_done_q <= init_done_d;
      data_done_q <= data_done_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign wr_data   = wr_data_q;
  assign p_wr_en   = p_wr_en_q;
  assign p_wr_addr = p_wr_addr_q;
  assign s_wr_en   = s_wr_en_q;
  assign s_wr_addr = s_wr_addr_q;
  assign init_done = init_done_q;
  assign data_done = data_done_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_bcrypt_core_din.sv
// -----------------------------------------------------------------------------
// tb_bcrypt_core_din
// Self-checking bench for bcrypt_core_din. A monitor collects every memory
// write and done pulse into shadow memories; each test builds the expected
// memory image straight from the batch word list and the address map.
// -----------------------------------------------------------------------------
module tb_bcrypt_core_din;
  import bcrypt_pkg::*;

`ifdef BCRYPT_DIN_CNT_CHECK_EN
  localparam bit CNT_CHECK = 1'b1;
`else
  localparam bit CNT_CHECK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic [1:0]  ctrl;
  logic        core_idle;
  logic [31:0] wr_data;
  logic        p_wr_en;
  logic [5:0]  p_wr_addr;
  logic        s_wr_en;
  logic [9:0]  s_wr_addr;
  logic        init_done;
  logic        data_done;
  logic        busy;
  logic [1:0]  error;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] cap_p [64];
  logic        cap_p_v [64];
  logic [31:0] cap_s [1024];
  logic        cap_s_v [1024];
  logic [31:0] exp_p [64];
  logic        exp_p_v [64];
  logic [31:0] exp_s [1024];
  logic        exp_s_v [1024];
  int p_writes, s_writes, init_pulses, data_pulses, overlaps, done_no_write;
  logic [31:0] words[$];

  bcrypt_core_din dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .din       (din),
    .ctrl      (ctrl),
    .core_idle (core_idle),
    .wr_data   (wr_data),
    .p_wr_en   (p_wr_en),
    .p_wr_addr (p_wr_addr),
    .s_wr_en   (s_wr_en),
    .s_wr_addr (s_wr_addr),
    .init_done (init_done),
    .data_done (data_done),
    .busy      (busy),
    .error     (error)
  );

  always #5 CLK = ~CLK;

  // Monitor: record writes and pulses half a cycle after each active edge
  always @(negedge CLK) begin
    if (rst_n === 1'b1) begin
      if (p_wr_en === 1'b1) begin
        cap_p[p_wr_addr] = wr_data;
        cap_p_v[p_wr_addr] = 1'b1;
        p_writes++;
      end
      if (s_wr_en === 1'b1) begin
        cap_s[s_wr_addr] = wr_data;
        cap_s_v[s_wr_addr] = 1'b1;
        s_writes++;
      end
      if (p_wr_en === 1'b1 && s_wr_en === 1'b1) overlaps++;
      if (init_done === 1'b1) init_pulses++;
      if (data_done === 1'b1) data_pulses++;
      if ((init_done === 1'b1 || data_done === 1'b1) && p_wr_en !== 1'b1 && s_wr_en !== 1'b1)
        done_no_write++;
    end
  end

  task automatic clear_capture();
    for (int i = 0; i < 64; i++) begin
      cap_p[i] = '0; cap_p_v[i] = 1'b0; exp_p[i] = '0; exp_p_v[i] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) begin
      cap_s[i] = '0; cap_s_v[i] = 1'b0; exp_s[i] = '0; exp_s_v[i] = 1'b0;
    end
    p_writes = 0; s_writes = 0; init_pulses = 0; data_pulses = 0;
    overlaps = 0; done_no_write = 0;
  endtask

  // Expected memory image for the first n words of a batch
  task automatic build_expected(input bit is_init, input int n);
    for (int i = 0; i < n; i++) begin
      if (!is_init) begin
        exp_p[DATA_BASE + i] = words[i]; exp_p_v[DATA_BASE + i] = 1'b1;
      end else if (i < INIT_P_WORDS) begin
        exp_p[i] = words[i]; exp_p_v[i] = 1'b1;
      end else begin
        exp_s[i - INIT_P_WORDS] = words[i]; exp_s_v[i - INIT_P_WORDS] = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] d);
    @(posedge CLK);
    #1;
    ctrl = c;
    din = d;
  endtask

  task automatic send_words(input int n, input bit end_last);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++)
        drive((end_last && i == n - 1 && b == 3) ? CTRL_END : CTRL_NONE, w[8*b +: 8]);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) drive(CTRL_NONE, 8'h00);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ctrl = CTRL_NONE; din = 8'h00; core_idle = 1'b1;
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    clear_capture();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    tests_run++;
    if ({wr_data, p_wr_en, p_wr_addr, s_wr_en, s_wr_addr} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_write_port: got %h/%b/%h/%b/%h, want all 0", wr_data, p_wr_en, p_wr_addr, s_wr_en, s_wr_addr);
    end
    tests_run++;
    if ({init_done, data_done, busy, error} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got done=%b%b busy=%b error=%b, want 0", init_done, data_done, busy, error);
    end
  endtask

  task automatic test_init();
    do_reset();
    words.delete();
    for (int n = 0; n < INIT_WORDS; n++) words.push_back(32'hA500_0000 + 32'(n));
    drive(CTRL_INIT_START, 8'hxx);
    send_words(INIT_WORDS, 1'b1);
    settle(3);
    build_expected(1'b1, INIT_WORDS);
    for (int i = 0; i < 64; i++) begin
      tests_run++;
      if (cap_p_v[i] !== exp_p_v[i] || cap_p[i] !== exp_p[i]) begin
        tests_failed++;
        $display("[TB] FAIL init_P[%0d]: got %b/%h, want %b/%h", i, cap_p_v[i], cap_p[i], exp_p_v[i], exp_p[i]);
      end
    end
    for (int i = 0; i < 1024; i++) begin
      tests_run++;
      if (cap_s_v[i] !== exp_s_v[i] || cap_s[i] !== exp_s[i]) begin
        tests_failed++;
        $display("[TB] FAIL init_S[%0d]: got %b/%h, want %b/%h", i, cap_s_v[i], cap_s[i], exp_s_v[i], exp_s[i]);
      end
    end
    tests_run++;
    if (cap_s[1023] !== 32'hA500_041D || cap_p[29] !== 32'hA500_001D) begin
      tests_failed++;
      $display("[TB] FAIL init_corners: got S1023=%h P29=%h, want a500041d/a500001d", cap_s[1023], cap_p[29]);
    end
    tests_run++;
    if (p_writes !== 30 || s_writes !== 1024 || overlaps !== 0) begin
      tests_failed++;
      $display("[TB] FAIL init_write_counts: got p=%0d s=%0d both=%0d, want 30/1024/0", p_writes, s_writes, overlaps);
    end
    tests_run++;
    if (init_pulses !== 1 || data_pulses !== 0 || done_no_write !== 0) begin
      tests_failed++;
      $display("[TB] FAIL init_done_pulse: got init=%0d data=%0d lone=%0d, want 1/0/0", init_pulses, data_pulses, done_no_write);
    end
    tests_run++;
    if (busy !== 1'b0 || error !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL init_end_status: got busy=%b error=%b, want 0/00", busy, error);
    end
  endtask

  // Data batch, either the fixed ramp or random words; checks write latency too
  task automatic test_data(input bit randomize_words);
    logic [31:0] w;
    do_reset();
    words.delete();
    for (int i = 0; i < DATA_WORDS; i++)
      words.push_back(randomize_words ? 32'($urandom) : 32'h1122_3344 + 32'(i));
    drive(CTRL_DATA_START, 8'hxx);
    for (int i = 0; i < DATA_WORDS; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        drive((i == DATA_WORDS - 1 && b == 3) ? CTRL_END : CTRL_NONE, w[8*b +: 8]);
        if (i == 1 && b == 0) begin
          @(negedge CLK);
          tests_run++;
          if (p_wr_en !== 1'b1 || p_wr_addr !== 6'd32 || wr_data !== words[0] || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL data_latency: got en=%b addr=%0d data=%h busy=%b, want 1/32/%h/1", p_wr_en, p_wr_addr, wr_data, busy, words[0]);
          end
        end
      end
    end
    settle(3);
    build_expected(1'b0, DATA_WORDS);
    for (int i = 0; i < 64; i++) begin
      tests_run++;
      if (cap_p_v[i] !== exp_p_v[i] || cap_p[i] !== exp_p[i]) begin
        tests_failed++;
        $display("[TB] FAIL data_P[%0d]: got %b/%h, want %b/%h", i, cap_p_v[i], cap_p[i], exp_p_v[i], exp_p[i]);
      end
    end
    tests_run++;
    if (s_writes !== 0 || p_writes !== DATA_WORDS) begin
      tests_failed++;
      $display("[TB] FAIL data_write_counts: got p=%0d s=%0d, want 31/0", p_writes, s_writes);
    end
    tests_run++;
    if (data_pulses !== 1 || init_pulses !== 0 || done_no_write !== 0 || busy !== 1'b0 || error !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL data_done: got data=%0d init=%0d lone=%0d busy=%b err=%b, want 1/0/0/0/00", data_pulses, init_pulses, done_no_write, busy, error);
    end
  endtask

  task automatic test_misaligned_end();
    logic [31:0] w;
    do_reset();
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(32'($urandom));
    drive(CTRL_DATA_START, 8'hxx);
    send_words(5, 1'b0);
    w = words[5];
    drive(CTRL_NONE, w[7:0]);
    drive(CTRL_NONE, w[15:8]);
    drive(CTRL_END, w[23:16]);
    settle(1);
    tests_run++;
    if (error !== 2'b01 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL misaligned_error: got error=%b busy=%b, want 01/1", error, busy);
    end
    send_words(8, 1'b1);
    settle(2);
    tests_run++;
    if (p_writes !== 5 || s_writes !== 0 || data_pulses !== 0 || error !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL misaligned_sticky: got p=%0d s=%0d done=%0d err=%b, want 5/0/0/01", p_writes, s_writes, data_pulses, error);
    end
  endtask

  task automatic test_start_while_busy();
    do_reset();
    core_idle = 1'b0;
    drive(CTRL_DATA_START, 8'hxx);
    settle(2);
    tests_run++;
    if (error !== 2'b10 || busy !== 1'b1 || p_writes !== 0) begin
      tests_failed++;
      $display("[TB] FAIL start_core_busy: got error=%b busy=%b p=%0d, want 10/1/0", error, busy, p_writes);
    end
    do_reset();
    words.delete();
    for (int i = 0; i < 2; i++) words.push_back(32'($urandom));
    drive(CTRL_DATA_START, 8'hxx);
    send_words(2, 1'b0);
    drive(CTRL_INIT_START, 8'hxx);
    settle(2);
    tests_run++;
    if (error !== 2'b01 || p_writes !== 2 || data_pulses !== 0) begin
      tests_failed++;
      $display("[TB] FAIL start_mid_batch: got error=%b p=%0d done=%0d, want 01/2/0", error, p_writes, data_pulses);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    words.delete();
    for (int i = 0; i < DATA_WORDS + 1; i++) words.push_back(32'($urandom));
    drive(CTRL_DATA_START, 8'hxx);
    send_words(DATA_WORDS + 1, 1'b0);
    settle(2);
    tests_run++;
    if (error !== 2'b01 || p_writes !== DATA_WORDS || data_pulses !== 0) begin
      tests_failed++;
      $display("[TB] FAIL overflow: got error=%b p=%0d done=%0d, want 01/31/0", error, p_writes, data_pulses);
    end
  endtask

  task automatic test_short_data();
    int want_done;
    logic [1:0] want_err;
    want_done = CNT_CHECK ? 0 : 1;
    want_err  = CNT_CHECK ? 2'b01 : 2'b00;
    do_reset();
    words.delete();
    for (int i = 0; i < DATA_WORDS - 1; i++) words.push_back(32'($urandom));
    drive(CTRL_DATA_START, 8'hxx);
    send_words(DATA_WORDS - 1, 1'b1);
    settle(2);
    tests_run++;
    if (data_pulses !== want_done || error !== want_err) begin
      tests_failed++;
      $display("[TB] FAIL short_data: got done=%0d error=%b, want %0d/%b", data_pulses, error, want_done, want_err);
    end
  endtask

  task automatic test_reset_mid_batch();
    logic [31:0] w;
    do_reset();
    words.delete();
    for (int i = 0; i < 11; i++) words.push_back(32'hA500_0000 + 32'(i));
    drive(CTRL_INIT_START, 8'hxx);
    send_words(10, 1'b0);
    w = words[10];
    for (int b = 0; b < 3; b++) drive(CTRL_NONE, w[8*b +: 8]);
    @(posedge CLK);
    #3;
    tests_run++;
    if (busy !== 1'b1 || wr_data !== 32'hA500_0009) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_state: got busy=%b data=%h, want 1/a5000009", busy, wr_data);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wr_data, p_wr_en, p_wr_addr, s_wr_en, s_wr_addr, init_done, data_done, busy, error} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got data=%h p=%b s=%b busy=%b err=%b, want all 0", wr_data, p_wr_en, s_wr_en, busy, error);
    end
    @(negedge CLK);
    ctrl = CTRL_NONE;
    rst_n = 1'b1;
    clear_capture();
    words.delete();
    for (int i = 0; i < DATA_WORDS; i++) words.push_back(32'($urandom));
    drive(CTRL_DATA_START, 8'hxx);
    send_words(DATA_WORDS, 1'b1);
    settle(3);
    build_expected(1'b0, DATA_WORDS);
    for (int i = 0; i < 64; i++) begin
      tests_run++;
      if (cap_p_v[i] !== exp_p_v[i] || cap_p[i] !== exp_p[i]) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_P[%0d]: got %b/%h, want %b/%h", i, cap_p_v[i], cap_p[i], exp_p_v[i], exp_p[i]);
      end
    end
    tests_run++;
    if (data_pulses !== 1 || error !== 2'b00 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_done: got done=%0d err=%b busy=%b, want 1/00/0", data_pulses, error, busy);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_data(1'b0);
    test_data(1'b1);
    test_misaligned_end();
    test_start_while_busy();
    test_overflow();
    test_short_data();
    test_reset_mid_batch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcrypt_core_din.md
Name: bcrypt_core_din

Overview:
- Core-side receiver for the 10-bit batch bus (dout[7:0] + ctrl[1:0]) driven by the bcrypt data distributor.
- Reassembles the byte stream into 32-bit words and writes them into the core's P/MW memory (64x32) and S memory (1024x32).
- Flags framing errors and pulses completion strobes to the core control FSM. Sits directly downstream of the data distributor, one per core.

Parameters:
- INIT_P_WORDS, 30, P + reserved + MW words at the start of an init batch, written to P addresses 0..29.
- S_WORDS, 1024, S words following the P words in an init batch.
- DATA_WORDS, 31, words in a data batch.
- DATA_BASE, 32, P address of the first data-batch word.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  8  byte from the bus; byte 0 of a word is bits [7:0], byte 3 is bits [31:24].
- ctrl  in  2  control code from the bus.
- core_idle  in  1  core is not using P/S memories.
- wr_data  out  32  assembled word.
- p_wr_en  out  1  write strobe for P memory.
- p_wr_addr  out  6  P memory address.
- s_wr_en  out  1  write strobe for S memory.
- s_wr_addr  out  10  S memory address.
- init_done  out  1  one-cycle pulse: init batch complete.
- data_done  out  1  one-cycle pulse: data batch complete.
- busy  out  1  a batch reception is in progress.
- error  out  2  sticky: [0] framing error, [1] start while core busy.

Behaviour:
- Reset: all outputs 0; state IDLE; byte and word counters 0; assembly register 0.
- Bus timing:
  - Start code appears for one cycle with din invalid.
  - Bytes follow, one per cycle, from the next cycle with ctrl=NONE.
  - END accompanies the last byte (byte 3 of the final word).
- State IDLE:
  - ctrl=INIT_START: go to RX_INIT.
  - ctrl=DATA_START: go to RX_DATA.
  - In both cases clear the counters and set busy=1. If core_idle=0 at that cycle, set error[1] and go to ERROR.
  - END or a byte in IDLE is ignored.
- States RX_INIT and RX_DATA:
  - Each cycle, shift din into byte position byte_cnt; byte_cnt wraps 3->0.
  - On byte_cnt==3, register the full word onto wr_data with one write strobe on the next cycle. Write latency is 1 cycle after the 4th byte.
- Address mapping:
  - RX_INIT words 0..29 -> p_wr_en, p_wr_addr = word index.
  - RX_INIT words 30..1053 -> s_wr_en, s_wr_addr = word-30.
  - RX_DATA word i -> p_wr_en, p_wr_addr = DATA_BASE+i.
  - Only one write enable is high per cycle; an address is held valid only while its enable is high.
- Termination:
  - END with byte_cnt==3 -> last word written next cycle.
  - In that same cycle, pulse init_done or data_done, busy<=0, return to IDLE.
- Framing errors (all set error[0] and go to ERROR):
  - END with byte_cnt!=3.
  - INIT_START or DATA_START received while in RX_INIT or RX_DATA.
  - Word count exceeding INIT_P_WORDS+S_WORDS (init) or DATA_WORDS (data) without END.
- State ERROR: sticky. No writes, busy=1, stays until rst_n.
- Reset asserted mid-batch: immediate return to IDLE, write enables drop asynchronously, partial word discarded.
- Word counter: 11 bits, no wrap, because the overflow check precedes wrap.

Optional Feature:
- Macro: BCRYPT_DIN_CNT_CHECK_EN.
- Defined: END on a word count other than exactly INIT_P_WORDS+S_WORDS (init) or DATA_WORDS (data) sets error[0] and goes to ERROR. No done pulse.
- Undefined: END is accepted at any word boundary; only the overflow and misaligned-END checks remain.

Decomposition:
- Shared package bcrypt_pkg:
  - ctrl encodings: CTRL_NONE=0, CTRL_INIT_START=1, CTRL_DATA_START=2, CTRL_END=3.
  - Word-count constants (30, 1024, 31, 32).
  - State enum.
- Sub-module bcrypt_byte_to_word: byte shifter with byte counter, emitting word + word_valid. Natural split, reusable elsewhere in the design.

Test Plan:
- Init batch: INIT_START, 1054 words where word n = 0xA5000000+n, END on the final byte -> P[0..29] = 0xA5000000..0xA500001D, S[0]=0xA500001E, S[1023]=0xA500041D, one init_done pulse, busy low after.
- Data batch: DATA_START, 31 words 0x11223344+i, bytes sent 0x44,0x33,0x22,0x11 -> P[32]=0x11223344, P[62]=0x11223362, data_done one pulse, no S writes.
- Misaligned END: END on byte 2 of word 5 in a data batch -> error=2'b01, no further writes, no done pulse, error held until rst_n.
- Start while busy: DATA_START with core_idle=0 -> error=2'b10; separately, INIT_START mid-RX_DATA -> error[0]=1.
- Reset mid-batch: rst_n low after 3 bytes of init word 10 -> all outputs 0 immediately; a fresh data batch after release completes normally.
- With BCRYPT_DIN_CNT_CHECK_EN: data batch with END after 30 words -> error[0]=1, no data_done. Without the macro: data_done asserted.
